// File: rtl/cache_request_arb_buffer_pkg.sv
// Shared definitions for the cache request arbiter/buffer: command encodings
// and the CLOG2 width helper.
`ifndef CACHE_REQUEST_ARB_BUFFER_CLOG2
`define CACHE_REQUEST_ARB_BUFFER_CLOG2
`define CLOG2(x) ($clog2(x))
`endif

package cache_request_arb_buffer_pkg;

    localparam int CMD_WIDTH       = 3;
    localparam int CMD_UNCACHED_BIT = 2;

    // The leading bit marks an uncached access; the buffer never interprets it.
    typedef enum logic [CMD_WIDTH-1:0] {
        CMD_WORD_READ      = 3'b000,
        CMD_WORD_WRITE     = 3'b001,
        CMD_BLOCK_READ     = 3'b010,
        CMD_BLOCK_WRITE    = 3'b011,
        CMD_UC_WORD_READ   = 3'b100,
        CMD_UC_WORD_WRITE  = 3'b101,
        CMD_UC_BLOCK_READ  = 3'b110,
        CMD_UC_BLOCK_WRITE = 3'b111
    } cache_cmd_e;

endpackage

// File: rtl/cache_request_arb_buffer_rr_arbiter.sv
// Round-robin arbiter: grants one requesting channel per cycle, searching
// upward from rr_ptr, which moves just past the last granted channel.
module rr_arbiter
    import cache_request_arb_buffer_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    localparam int BW_CH = (N_CHANNELS > 1) ? `CLOG2(N_CHANNELS) : 1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic [N_CHANNELS-1:0] request,
    input  logic                  enable,
    output logic [N_CHANNELS-1:0] grant
);

    logic [BW_CH-1:0] rr_ptr;
    logic [BW_CH-1:0] grant_idx;
    logic             found;
    int               idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_CHANNELS) idx = idx - N_CHANNELS;
            if (enable && !found && request[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = BW_CH'(idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rr_ptr <= '0;
        end else if (found) begin
            rr_ptr <= (grant_idx == BW_CH'(N_CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/cache_request_arb_buffer.sv
// Multi-channel cache request buffer: a round-robin arbiter picks one channel
// per cycle into a circular FIFO; the head entry is presented combinationally.
module cache_request_arb_buffer
    import cache_request_arb_buffer_pkg::*;
#(
    parameter int N_ENTRIES   = 8,
    parameter int N_CHANNELS  = 4,
    parameter int BW_COMMAND  = 3,
    parameter int BW_ADDR     = 32,
    parameter int BW_DATA     = 128,
    parameter int ALMOST_FULL = N_ENTRIES - 2,
    localparam int BW_ENTRIES = `CLOG2(N_ENTRIES),
    localparam int BW_CH      = (N_CHANNELS > 1) ? `CLOG2(N_CHANNELS) : 1
) (
    input  logic                             clock_i,
    input  logic                             reset_i,
    input  logic [N_CHANNELS-1:0]            write_i,
    input  logic [N_CHANNELS*BW_COMMAND-1:0] command_i,
    input  logic [N_CHANNELS*BW_ADDR-1:0]    addr_i,
    input  logic [N_CHANNELS*BW_DATA-1:0]    data_i,
    output logic [N_CHANNELS-1:0]            grant_o,
    input  logic                             flush_i,
    output logic                             full_o,
    output logic                             almost_full_o,
    output logic [BW_ENTRIES:0]              count_o,
    input  logic                             read_i,
    output logic                             empty_o,
    output logic [BW_COMMAND-1:0]            command_o,
    output logic [BW_ADDR-1:0]               addr_o,
    output logic [BW_DATA-1:0]               data_o,
    output logic [BW_CH-1:0]                 src_o
);

    logic [BW_COMMAND-1:0] cmd_mem  [N_ENTRIES];
    logic [BW_ADDR-1:0]    addr_mem [N_ENTRIES];
    logic [BW_DATA-1:0]    data_mem [N_ENTRIES];
    logic [BW_CH-1:0]      src_mem  [N_ENTRIES];

    logic [BW_ENTRIES-1:0] read_ptr;
    logic [BW_ENTRIES-1:0] write_ptr;
    logic [BW_ENTRIES:0]   count;

    logic                  enq_enable;
    logic                  enq;
    logic                  deq;
    logic [BW_COMMAND-1:0] wr_cmd;
    logic [BW_ADDR-1:0]    wr_addr;
    logic [BW_DATA-1:0]    wr_data;
    logic [BW_CH-1:0]      wr_src;

    assign count_o       = count;
    assign empty_o       = (count == '0);
    assign full_o        = (count == (BW_ENTRIES+1)'(N_ENTRIES));
    assign almost_full_o = (count >= (BW_ENTRIES+1)'(ALMOST_FULL));

    // At full, a simultaneous read frees the slot being written (pass-through).
    assign enq_enable = !reset_i && !flush_i && (!full_o || read_i);
    assign enq        = |grant_o;
    assign deq        = read_i && !empty_o && !flush_i;

    rr_arbiter #(.N_CHANNELS(N_CHANNELS)) u_rr_arbiter (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .request (write_i),
        .enable  (enq_enable),
        .grant   (grant_o)
    );

    always_comb begin
        wr_cmd  = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_src  = '0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            if (grant_o[k]) begin
                wr_cmd  = command_i[k*BW_COMMAND +: BW_COMMAND];
                wr_addr = addr_i[k*BW_ADDR +: BW_ADDR];
                wr_data = data_i[k*BW_DATA +: BW_DATA];
                wr_src  = BW_CH'(k);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            read_ptr  <= '0;
            write_ptr <= '0;
            count     <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                cmd_mem[i]  <= '0;
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
                src_mem[i]  <= '0;
            end
        end else if (flush_i) begin
            read_ptr  <= '0;
            write_ptr <= '0;
            count     <= '0;
        end else begin
            if (enq) begin
                cmd_mem[write_ptr]  <= wr_cmd;
                addr_mem[write_ptr] <= wr_addr;
                data_mem[write_ptr] <= wr_data;
                src_mem[write_ptr]  <= wr_src;
                write_ptr           <= write_ptr + 1'b1;
            end
            if (deq) read_ptr <= read_ptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (deq && !enq) count <= count - 1'b1;
        end
    end

    assign command_o = cmd_mem[read_ptr];
    assign addr_o    = addr_mem[read_ptr];
    assign data_o    = data_mem[read_ptr];
    assign src_o     = src_mem[read_ptr];

endmodule

// File: tb/tb_cache_request_arb_buffer.sv
// Directed bench for cache_request_arb_buffer (4 channels, 8 entries).
module tb_cache_request_arb_buffer;
    import cache_request_arb_buffer_pkg::*;

    localparam int NC = 4;
    localparam int NE = 8;

    logic            clock_i = 1'b0;
    logic            reset_i = 1'b1;
    logic [NC-1:0]   write_i = '0;
    logic [NC*3-1:0] command_i = '0;
    logic [NC*32-1:0] addr_i = '0;
    logic [NC*128-1:0] data_i = '0;
    logic [NC-1:0]   grant_o;
    logic            flush_i = 1'b0;
    logic            full_o;
    logic            almost_full_o;
    logic [3:0]      count_o;
    logic            read_i = 1'b0;
    logic            empty_o;
    logic [2:0]      command_o;
    logic [31:0]     addr_o;
    logic [127:0]    data_o;
    logic [1:0]      src_o;

    int n_checks = 0;
    int n_pass   = 0;

    cache_request_arb_buffer #(.N_ENTRIES(NE), .N_CHANNELS(NC)) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .write_i       (write_i),
        .command_i     (command_i),
        .addr_i        (addr_i),
        .data_i        (data_i),
        .grant_o       (grant_o),
        .flush_i       (flush_i),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .count_o       (count_o),
        .read_i        (read_i),
        .empty_o       (empty_o),
        .command_o     (command_o),
        .addr_o        (addr_o),
        .data_o        (data_o),
        .src_o         (src_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic load_ch(input int k, input logic [2:0] cmd, input logic [31:0] a);
        command_i[k*3 +: 3]    = cmd;
        addr_i[k*32 +: 32]     = a;
        data_i[k*128 +: 128]   = {4{a}};
    endtask

    initial begin
        // Reset state, with requests already asserted.
        write_i = 4'b1111;
        #2;
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_afull", almost_full_o, 0);
        check("rst_count", count_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_addr", addr_o, 0);
        write_i = '0;
        tick();
        reset_i = 1'b0;
        tick();

        // Round-robin across all four channels, then drain in order.
        for (int i = 0; i < NC; i++) load_ch(i, 3'(i), 32'h100 + i);
        write_i = 4'b1111;
        for (int i = 0; i < NC; i++) begin
            #1 check($sformatf("rr_grant%0d", i), grant_o, 4'b0001 << i);
            tick();
        end
        write_i = '0;
        #1 check("rr_count4", count_o, 4);
        read_i = 1'b1;
        for (int i = 0; i < NC; i++) begin
            check($sformatf("rr_src%0d", i), src_o, i);
            check($sformatf("rr_addr%0d", i), addr_o, 32'h100 + i);
            check($sformatf("rr_cmd%0d", i), command_o, i);
            tick();
        end
        read_i = 1'b0;
        check("rr_count0", count_o, 0);
        check("rr_empty", empty_o, 1);

        // Fill to full from channel 0; almost_full from 6.
        write_i = 4'b0001;
        for (int i = 0; i < NE; i++) begin
            load_ch(0, CMD_WORD_WRITE, 32'h200 + i);
            #1 check($sformatf("fill_grant%0d", i), grant_o, 4'b0001);
            tick();
            check($sformatf("fill_count%0d", i), count_o, i + 1);
            check($sformatf("fill_afull%0d", i), almost_full_o, (i + 1) >= 6);
        end
        check("fill_full", full_o, 1);
        write_i = 4'b1111;
        #1 check("full_nogrant", grant_o, 0);
        tick();
        write_i = '0;
        check("full_count_hold", count_o, 8);
        check("full_head", addr_o, 32'h200);

        // Pass-through at full: ch2 lands in the slot just vacated.
        load_ch(2, CMD_UC_BLOCK_WRITE, 32'h300);
        write_i = 4'b0100;
        read_i  = 1'b1;
        #1 check("pt_grant", grant_o, 4'b0100);
        tick();
        write_i = '0;
        read_i  = 1'b0;
        check("pt_count", count_o, 8);
        check("pt_head", addr_o, 32'h201);
        read_i = 1'b1;
        for (int i = 1; i < NE; i++) begin
            check($sformatf("drain_addr%0d", i), addr_o, 32'h200 + i);
            tick();
        end
        check("pt_last_addr", addr_o, 32'h300);
        check("pt_last_src", src_o, 2);
        check("pt_last_cmd", command_o, CMD_UC_BLOCK_WRITE);
        check("pt_last_data", data_o, {4{32'h300}});
        tick();
        read_i = 1'b0;
        check("pt_empty", empty_o, 1);

        // Enqueue into empty: visible next cycle, no bypass.
        load_ch(1, CMD_UC_WORD_READ, 32'h1000);
        write_i = 4'b0010;
        #1 check("emp_grant", grant_o, 4'b0010);
        check("emp_still_empty", empty_o, 1);
        tick();
        write_i = '0;
        check("emp_not_empty", empty_o, 0);
        check("emp_addr", addr_o, 32'h1000);
        check("emp_cmd", command_o, CMD_UC_WORD_READ);
        read_i = 1'b1;
        tick();
        check("emp_popped", count_o, 0);
        tick();
        read_i = 1'b0;
        check("emp_read_ignored", count_o, 0);
        check("emp_empty", empty_o, 1);

        // Flush beats simultaneous read and write.
        write_i = 4'b0001;
        for (int i = 0; i < 5; i++) tick();
        check("fl_count5", count_o, 5);
        flush_i = 1'b1;
        read_i  = 1'b1;
        #1 check("fl_grant", grant_o, 0);
        tick();
        flush_i = 1'b0;
        read_i  = 1'b0;
        write_i = '0;
        check("fl_count", count_o, 0);
        check("fl_empty", empty_o, 1);
        check("fl_full", full_o, 0);

        // Reset mid-burst; rr pointer must restart at channel 0.
        load_ch(1, CMD_BLOCK_READ, 32'h401);
        load_ch(2, CMD_BLOCK_READ, 32'h402);
        load_ch(3, CMD_BLOCK_READ, 32'h403);
        write_i = 4'b0110;
        for (int i = 0; i < 3; i++) tick();
        check("mr_count3", count_o, 3);
        #2 reset_i = 1'b1;
        #1;
        check("mr_count", count_o, 0);
        check("mr_empty", empty_o, 1);
        check("mr_grant", grant_o, 0);
        check("mr_addr", addr_o, 0);
        check("mr_data", data_o, 0);
        check("mr_src", src_o, 0);
        check("mr_cmd", command_o, 0);
        tick();
        reset_i = 1'b0;
        write_i = 4'b1010;
        #1 check("mr_first_grant", grant_o, 4'b0010);
        tick();
        write_i = '0;
        check("mr_after_count", count_o, 1);
        check("mr_after_src", src_o, 1);
        check("mr_after_addr", addr_o, 32'h401);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
